// File: rtl/rename_queue.sv
// Rename queue between decode and dispatch: a DEPTH-entry bundle FIFO with
// first-word-fall-through head, capability-lane flags and saturating statistics.
package rename_queue_pkg;
  localparam int TAG_W = 4;

  typedef enum logic [TAG_W-1:0] {
    UOP_INT_ALU  = 4'd0,
    UOP_INT_MUL  = 4'd1,
    UOP_LD_U8    = 4'd2,
    UOP_ST       = 4'd3,
    UOP_BRANCH   = 4'd4,
    UOP_CAP_JUMP = 4'd5,
    UOP_CAP_RET  = 4'd6,
    UOP_LINK     = 4'd7
  } uop_tag_t;

  function automatic logic is_cap_tag(input logic [TAG_W-1:0] tag);
    case (tag)
      UOP_CAP_JUMP, UOP_CAP_RET, UOP_LINK: is_cap_tag = 1'b1;
      default:                             is_cap_tag = 1'b0;
    endcase
  endfunction
endpackage

module rename_queue
  import rename_queue_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  input  logic                                 decode_valid_i,
  input  logic [LANES-1:0][TAG_W-1:0]          decode_uops_i,
  input  logic [$clog2(LANES+1)-1:0]           decode_uop_count_i,
  output logic                                 rename_ready_o,
  output logic                                 dispatch_valid_o,
  output logic [LANES-1:0][TAG_W-1:0]          dispatch_uops_o,
  output logic [$clog2(LANES+1)-1:0]           dispatch_uop_count_o,
  input  logic                                 dispatch_ready_i,
  output logic [LANES-1:0]                     lane_is_capability_o,
  output logic [$clog2(DEPTH+1)-1:0]           occupancy_o,
  output logic [CNT_W-1:0]                     uops_issued_count_o,
  output logic [CNT_W-1:0]                     capability_issued_count_o,
  output logic [CNT_W-1:0]                     stall_cycles_o
);

  localparam int CW = $clog2(LANES + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LANES_C = CW'(LANES);
  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

  typedef struct packed {
    logic [CW-1:0]                 cnt;
    logic [LANES-1:0][TAG_W-1:0]   uops;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic [CNT_W-1:0]  uops_cnt_q, uops_cnt_d;
  logic [CNT_W-1:0]  cap_cnt_q, cap_cnt_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic              push_s;
  logic              pop_s;
  logic [CW-1:0]     cnt_clamped_s;
  entry_t            head_s;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[CNT_W]) begin
      sat_add = {CNT_W{1'b1}};
    end else begin
      sat_add = sum[CNT_W-1:0];
    end
  endfunction

  function automatic logic [CW-1:0] popcnt(input logic [LANES-1:0] v);
    popcnt = {CW{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      popcnt = popcnt + CW'(v[i]);
    end
  endfunction

  // Handshake qualification; ready and valid come from registered occupancy only.
  always_comb begin
    rename_ready_o   = (occ_q < DEPTH_C);
    dispatch_valid_o = (occ_q != {OW{1'b0}});
    if (decode_uop_count_i > LANES_C) begin
      cnt_clamped_s = LANES_C;
    end else begin
      cnt_clamped_s = decode_uop_count_i;
    end
    push_s = decode_valid_i && rename_ready_o && !flush_i &&
             (decode_uop_count_i != {CW{1'b0}});
    pop_s  = dispatch_valid_o && dispatch_ready_i;
  end

  // Head presentation: lanes beyond the stored count read back as plain ALU uops.
  always_comb begin
    head_s               = mem_q[rd_ptr_q];
    dispatch_uop_count_o = {CW{1'b0}};
    dispatch_uops_o      = {(LANES*TAG_W){1'b0}};
    lane_is_capability_o = {LANES{1'b0}};
    if (dispatch_valid_o) begin
      dispatch_uop_count_o = head_s.cnt;
    end else begin
      dispatch_uop_count_o = {CW{1'b0}};
    end
    for (int i = 0; i < LANES; i++) begin
      if (dispatch_valid_o && (CW'(i) < head_s.cnt)) begin
        dispatch_uops_o[i]      = head_s.uops[i];
        lane_is_capability_o[i] = is_cap_tag(head_s.uops[i]);
      end else begin
        dispatch_uops_o[i]      = UOP_INT_ALU;
        lane_is_capability_o[i] = 1'b0;
      end
    end
  end

  // Queue storage and pointer/occupancy next state; flush wins over any push.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = '{cnt: cnt_clamped_s, uops: decode_uops_i};
    end else begin
      mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
    end
    if (flush_i) begin
      rd_ptr_d = {PW{1'b0}};
      wr_ptr_d = {PW{1'b0}};
      occ_d    = {OW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   occ_d = occ_q + OW'(1);
        2'b01:   occ_d = occ_q - OW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // Statistics; a pop during flush is still counted because dispatch took it.
  always_comb begin
    uops_cnt_d = uops_cnt_q;
    cap_cnt_d  = cap_cnt_q;
    stall_d    = stall_q;
    if (pop_s) begin
      uops_cnt_d = sat_add(uops_cnt_q, CNT_W'(dispatch_uop_count_o));
      cap_cnt_d  = sat_add(cap_cnt_q, CNT_W'(popcnt(lane_is_capability_o)));
    end else begin
      uops_cnt_d = uops_cnt_q;
      cap_cnt_d  = cap_cnt_q;
    end
    if (dispatch_valid_o && !dispatch_ready_i && !flush_i) begin
      stall_d = sat_add(stall_q, CNT_W'(1'b1));
    end else begin
      stall_d = stall_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {$bits(entry_t){1'b0}};
      end
      rd_ptr_q   <= {PW{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      occ_q      <= {OW{1'b0}};
      uops_cnt_q <= {CNT_W{1'b0}};
      cap_cnt_q  <= {CNT_W{1'b0}};
      stall_q    <= {CNT_W{1'b0}};
    end else begin
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      uops_cnt_q <= uops_cnt_d;
      cap_cnt_q  <= cap_cnt_d;
      stall_q    <= stall_d;
    end
  end

  assign occupancy_o               = occ_q;
  assign uops_issued_count_o       = uops_cnt_q;
  assign capability_issued_count_o = cap_cnt_q;
  assign stall_cycles_o            = stall_q;

endmodule

// File: tb/tb_rename_queue.sv
// Directed bench for rename_queue: a vector table on the default instance plus
// short sequences on a single-lane instance and a narrow-counter instance.
module tb_rename_queue;
  import rename_queue_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // shared / instance A (LANES=2, DEPTH=4, CNT_W=16)
  logic            flush, dv, dr;
  logic [1:0][3:0] uops;
  logic [1:0]      cnt;
  logic            a_rdy, a_vld;
  logic [1:0][3:0] a_uops;
  logic [1:0]      a_cnt, a_cap;
  logic [2:0]      a_occ;
  logic [15:0]     a_ui, a_ci, a_st;

  // instance B (LANES=1)
  logic            dv_b;
  logic [0:0][3:0] uops_b;
  logic [0:0]      cnt_b;
  logic            b_rdy, b_vld;
  logic [0:0][3:0] b_uops;
  logic [0:0]      b_cnt, b_cap;
  logic [2:0]      b_occ;
  logic [15:0]     b_ui, b_ci, b_st;

  // instance C (CNT_W=4), same decode inputs as A
  logic            c_rdy, c_vld;
  logic [1:0][3:0] c_uops;
  logic [1:0]      c_cnt, c_cap;
  logic [2:0]      c_occ;
  logic [3:0]      c_ui, c_ci, c_st;

  rename_queue #(.LANES(2), .DEPTH(4), .CNT_W(16)) u_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .decode_valid_i(dv),
    .decode_uops_i(uops), .decode_uop_count_i(cnt), .rename_ready_o(a_rdy),
    .dispatch_valid_o(a_vld), .dispatch_uops_o(a_uops), .dispatch_uop_count_o(a_cnt),
    .dispatch_ready_i(dr), .lane_is_capability_o(a_cap), .occupancy_o(a_occ),
    .uops_issued_count_o(a_ui), .capability_issued_count_o(a_ci), .stall_cycles_o(a_st));

  rename_queue #(.LANES(1), .DEPTH(4), .CNT_W(16)) u_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .decode_valid_i(dv_b),
    .decode_uops_i(uops_b), .decode_uop_count_i(cnt_b), .rename_ready_o(b_rdy),
    .dispatch_valid_o(b_vld), .dispatch_uops_o(b_uops), .dispatch_uop_count_o(b_cnt),
    .dispatch_ready_i(dr), .lane_is_capability_o(b_cap), .occupancy_o(b_occ),
    .uops_issued_count_o(b_ui), .capability_issued_count_o(b_ci), .stall_cycles_o(b_st));

  rename_queue #(.LANES(2), .DEPTH(4), .CNT_W(4)) u_c (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .decode_valid_i(dv),
    .decode_uops_i(uops), .decode_uop_count_i(cnt), .rename_ready_o(c_rdy),
    .dispatch_valid_o(c_vld), .dispatch_uops_o(c_uops), .dispatch_uop_count_o(c_cnt),
    .dispatch_ready_i(dr), .lane_is_capability_o(c_cap), .occupancy_o(c_occ),
    .uops_issued_count_o(c_ui), .capability_issued_count_o(c_ci), .stall_cycles_o(c_st));

  typedef struct packed {
    logic       f;
    logic       dv;
    logic [7:0] u;
    logic [1:0] c;
    logic       dr;
  } vin_t;

  typedef struct packed {
    logic        rdy;
    logic        vld;
    logic [1:0]  cnt;
    logic [7:0]  uops;
    logic [1:0]  cap;
    logic [2:0]  occ;
    logic [15:0] ui;
    logic [15:0] ci;
    logic [15:0] st;
  } vout_t;

  typedef struct packed {
    vin_t  i;
    vout_t o;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t v(input logic f, input logic d, input logic [7:0] u,
                             input logic [1:0] c, input logic r, input logic rdy,
                             input logic vld, input logic [1:0] oc, input logic [7:0] ou,
                             input logic [1:0] cap, input logic [2:0] occ,
                             input logic [15:0] ui, input logic [15:0] ci,
                             input logic [15:0] st);
    vec_t x;
    x.i = '{f, d, u, c, r};
    x.o = '{rdy, vld, oc, ou, cap, occ, ui, ci, st};
    return x;
  endfunction

  function automatic vout_t observe_a();
    vout_t o;
    o = '{a_rdy, a_vld, a_cnt, a_uops, a_cap, a_occ, a_ui, a_ci, a_st};
    return o;
  endfunction

  task automatic drive(input vin_t x);
    flush = x.f;
    dv    = x.dv;
    uops  = x.u;
    cnt   = x.c;
    dr    = x.dr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_vec(input string nm, input vout_t got, input vout_t exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got rdy=%0b vld=%0b cnt=%0d uops=%h cap=%b occ=%0d ui=%0d ci=%0d st=%0d | want rdy=%0b vld=%0b cnt=%0d uops=%h cap=%b occ=%0d ui=%0d ci=%0d st=%0d",
               nm, got.rdy, got.vld, got.cnt, got.uops, got.cap, got.occ, got.ui, got.ci, got.st,
               exp.rdy, exp.vld, exp.cnt, exp.uops, exp.cap, exp.occ, exp.ui, exp.ci, exp.st);
    end
  endtask

  task automatic chk_val(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    flush = 1'b0; dv = 1'b0; uops = 8'h00; cnt = 2'd0; dr = 1'b1;
    dv_b  = 1'b0; uops_b = 4'h0; cnt_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    //            f  dv  u      c     dr    rdy  vld  oc    ou     cap    occ   ui  ci  st
    vecs[0]  = v(0, 0, 8'h00, 2'd0, 1,    1,   0, 2'd0, 8'h00, 2'b00, 3'd0,  0,  0,  0);
    vecs[1]  = v(0, 1, 8'h75, 2'd2, 1,    1,   1, 2'd2, 8'h75, 2'b11, 3'd1,  0,  0,  0);
    vecs[2]  = v(0, 0, 8'h00, 2'd0, 1,    1,   0, 2'd0, 8'h00, 2'b00, 3'd0,  2,  2,  0);
    vecs[3]  = v(0, 1, 8'h61, 2'd1, 0,    1,   1, 2'd1, 8'h01, 2'b00, 3'd1,  2,  2,  0);
    vecs[4]  = v(0, 1, 8'h62, 2'd1, 0,    1,   1, 2'd1, 8'h01, 2'b00, 3'd2,  2,  2,  1);
    vecs[5]  = v(0, 1, 8'h63, 2'd1, 0,    1,   1, 2'd1, 8'h01, 2'b00, 3'd3,  2,  2,  2);
    vecs[6]  = v(0, 1, 8'h65, 2'd1, 0,    0,   1, 2'd1, 8'h01, 2'b00, 3'd4,  2,  2,  3);
    vecs[7]  = v(0, 1, 8'h64, 2'd1, 0,    0,   1, 2'd1, 8'h01, 2'b00, 3'd4,  2,  2,  4);
    vecs[8]  = v(0, 0, 8'h00, 2'd0, 1,    1,   1, 2'd1, 8'h02, 2'b00, 3'd3,  3,  2,  4);
    vecs[9]  = v(0, 0, 8'h00, 2'd0, 1,    1,   1, 2'd1, 8'h03, 2'b00, 3'd2,  4,  2,  4);
    vecs[10] = v(0, 0, 8'h00, 2'd0, 1,    1,   1, 2'd1, 8'h05, 2'b01, 3'd1,  5,  2,  4);
    vecs[11] = v(0, 0, 8'h00, 2'd0, 1,    1,   0, 2'd0, 8'h00, 2'b00, 3'd0,  6,  3,  4);
    vecs[12] = v(0, 1, 8'h65, 2'd0, 1,    1,   0, 2'd0, 8'h00, 2'b00, 3'd0,  6,  3,  4);
    vecs[13] = v(0, 1, 8'h62, 2'd2, 1,    1,   1, 2'd2, 8'h62, 2'b10, 3'd1,  6,  3,  4);
    vecs[14] = v(0, 0, 8'h00, 2'd0, 1,    1,   0, 2'd0, 8'h00, 2'b00, 3'd0,  8,  4,  4);
    vecs[15] = v(0, 1, 8'h75, 2'd3, 1,    1,   1, 2'd2, 8'h75, 2'b11, 3'd1,  8,  4,  4);
    vecs[16] = v(0, 0, 8'h00, 2'd0, 1,    1,   0, 2'd0, 8'h00, 2'b00, 3'd0, 10,  6,  4);
    vecs[17] = v(0, 1, 8'h01, 2'd1, 1,    1,   1, 2'd1, 8'h01, 2'b00, 3'd1, 10,  6,  4);
    vecs[18] = v(0, 1, 8'h77, 2'd2, 1,    1,   1, 2'd2, 8'h77, 2'b11, 3'd1, 11,  6,  4);
    vecs[19] = v(0, 0, 8'h00, 2'd0, 1,    1,   0, 2'd0, 8'h00, 2'b00, 3'd0, 13,  8,  4);
    vecs[20] = v(0, 1, 8'h01, 2'd1, 0,    1,   1, 2'd1, 8'h01, 2'b00, 3'd1, 13,  8,  4);
    vecs[21] = v(0, 1, 8'h02, 2'd1, 0,    1,   1, 2'd1, 8'h01, 2'b00, 3'd2, 13,  8,  5);
    vecs[22] = v(0, 1, 8'h03, 2'd1, 0,    1,   1, 2'd1, 8'h01, 2'b00, 3'd3, 13,  8,  6);
    vecs[23] = v(0, 1, 8'h04, 2'd1, 0,    0,   1, 2'd1, 8'h01, 2'b00, 3'd4, 13,  8,  7);
    vecs[24] = v(0, 1, 8'h05, 2'd1, 1,    1,   1, 2'd1, 8'h02, 2'b00, 3'd3, 14,  8,  7);
    vecs[25] = v(1, 1, 8'h55, 2'd2, 0,    1,   0, 2'd0, 8'h00, 2'b00, 3'd0, 14,  8,  7);
    vecs[26] = v(0, 1, 8'h07, 2'd1, 1,    1,   1, 2'd1, 8'h07, 2'b01, 3'd1, 14,  8,  7);
    vecs[27] = v(1, 0, 8'h00, 2'd0, 1,    1,   0, 2'd0, 8'h00, 2'b00, 3'd0, 15,  9,  7);
    vecs[28] = v(0, 0, 8'h00, 2'd0, 1,    1,   0, 2'd0, 8'h00, 2'b00, 3'd0, 15,  9,  7);

    // Single-lane instance sees the capability bundle's lane 0 only.
    do_reset();
    chk_val("b_reset_ready", {31'd0, b_rdy}, 32'd1);
    dv = 1'b1; uops = 8'h75; cnt = 2'd2;
    dv_b = 1'b1; uops_b = UOP_CAP_JUMP; cnt_b = 1'b1;
    step();
    chk_val("b_valid", {31'd0, b_vld}, 32'd1);
    chk_val("b_cap_flag", {31'd0, b_cap}, 32'd1);
    dv = 1'b0; dv_b = 1'b0;
    step();
    chk_val("b_cap_count", {16'd0, b_ci}, 32'd1);
    chk_val("b_uop_count", {16'd0, b_ui}, 32'd1);
    chk_val("b_drained", {31'd0, b_vld}, 32'd0);

    do_reset();
    for (int k = 0; k < NV; k++) begin
      drive(vecs[k].i);
      step();
      chk_vec($sformatf("vec%0d", k), observe_a(), vecs[k].o);
    end

    // Narrow counters saturate under a steady stream of two-capability bundles.
    do_reset();
    flush = 1'b0; dv = 1'b1; uops = 8'h75; cnt = 2'd2; dr = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 8) begin
        chk_val("c_cap_pre_sat", {28'd0, c_ci}, 32'd14);
        chk_val("c_uop_pre_sat", {28'd0, c_ui}, 32'd14);
      end
      if (k == 10) begin
        chk_val("c_cap_sat", {28'd0, c_ci}, 32'd15);
        chk_val("c_uop_sat", {28'd0, c_ui}, 32'd15);
      end
    end
    chk_val("c_occ_streaming", {29'd0, c_occ}, 32'd1);

    // Reset asserted between edges must clear immediately.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_val("c_rst_occ", {29'd0, c_occ}, 32'd0);
    chk_val("c_rst_valid", {31'd0, c_vld}, 32'd0);
    chk_val("c_rst_ready", {31'd0, c_rdy}, 32'd1);
    chk_val("c_rst_cap", {28'd0, c_ci}, 32'd0);
    chk_val("c_rst_uops", {28'd0, c_ui}, 32'd0);
    chk_val("a_rst_occ", {29'd0, a_occ}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dv = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rename_queue.md
Name: rename_queue

Overview:
- Parametrised successor to the single-slot rename stub; sits between decode and dispatch.
- Buffers decode bundles of up to LANES uop tags in a DEPTH-entry FIFO, decoupling decode from dispatch back-pressure.
- Flags capability lanes and keeps saturating issue, capability and stall statistics.
- Supports pipeline flush.

Parameters:
- LANES, 2, uops per bundle (>=1).
- DEPTH, 4, bundle entries in queue (power of 2, >=2).
- CNT_W, 16, width of statistics counters.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, asynchronous, active-high.
- flush_i  input  1  discard all queued bundles.
- decode_valid_i  input  1  decode bundle valid.
- decode_uops_i  input  LANES x uop_tag_t  bundle tags; lane 0 = oldest.
- decode_uop_count_i  input  $clog2(LANES+1)  valid uops in bundle.
- rename_ready_o  output  1  queue can accept a bundle.
- dispatch_valid_o  output  1  head bundle valid.
- dispatch_uops_o  output  LANES x uop_tag_t  head bundle tags.
- dispatch_uop_count_o  output  $clog2(LANES+1)  head uop count.
- dispatch_ready_i  input  1  dispatch accepts head.
- lane_is_capability_o  output  LANES  per-lane capability flag for head.
- occupancy_o  output  $clog2(DEPTH+1)  queued bundles.
- uops_issued_count_o  output  CNT_W  uops handed to dispatch.
- capability_issued_count_o  output  CNT_W  capability uops handed to dispatch.
- stall_cycles_o  output  CNT_W  cycles head valid but dispatch not ready.

Behaviour:
- Reset (async assert, sync release): queue empty; occupancy_o=0; all counters 0; dispatch_valid_o=0; rename_ready_o=1.
- Push: decode_valid_i && rename_ready_o && !flush_i && count!=0.
  - Bundles with count 0 are consumed (handshake completes) but not enqueued.
  - Count > LANES is clamped to LANES before storing.
- rename_ready_o = (occupancy_o < DEPTH). Registered state only; no combinational path from dispatch_ready_i. A full queue therefore refuses a push even in a cycle with a simultaneous pop.
- Pop: dispatch_valid_o && dispatch_ready_i.
- dispatch_valid_o = (occupancy_o != 0). First-word-fall-through from the head entry. No bypass, so an empty→push→visible latency is 1 cycle.
- dispatch_uops_o: lanes >= stored count driven as UOP_INT_ALU. dispatch_uop_count_o = stored count. Both are 0/UOP_INT_ALU when empty.
- lane_is_capability_o[i] = dispatch_valid_o && i<count && tag in {UOP_CAP_JUMP, UOP_CAP_RET, UOP_LINK}.
- Simultaneous push and pop (not full): occupancy unchanged, pointers both advance. Pointers wrap modulo DEPTH.
- On pop:
  - uops_issued_count_o += count.
  - capability_issued_count_o += popcount(lane_is_capability_o).
  - Both saturate at 2^CNT_W-1 and never wrap.
- stall_cycles_o += 1 each cycle dispatch_valid_o && !dispatch_ready_i && !flush_i; saturating.
- flush_i: at the next edge pointers reset and occupancy=0. Any push that cycle is dropped. A pop in the flush cycle still counts in statistics (dispatch saw it). Counters are otherwise retained.
- Reset mid-operation: immediate return to reset state regardless of flush or handshakes.

Test Plan:
- Reset, then idle with dispatch_ready_i=1 → rename_ready_o=1, dispatch_valid_o=0, all counters 0.
- LANES=2: push {UOP_CAP_JUMP, UOP_LINK} count 2, dispatch_ready_i=1 → valid 1 cycle later; lane_is_capability_o=2'b11; after pop capability_issued_count_o=2, uops_issued_count_o=2. LANES=1 instance with the same stimulus → flag 1'b1, capability count 1.
- dispatch_ready_i=0, push 5 count-1 bundles with DEPTH=4 → 4 accepted, rename_ready_o=0 at occupancy 4, stall_cycles_o increments each cycle. Then ready=1 → FIFO order preserved, drained in 4 cycles.
- Push {UOP_CAP_JUMP, UOP_CAP_RET} with count 0 → not queued, occupancy 0, counters unchanged. Push {UOP_LD_U8, UOP_CAP_RET} count 2 → flags 2'b10 (lane1 only), capability count +1.
- Fill 3 entries, assert flush_i with simultaneous push → next cycle occupancy 0, dispatch_valid_o=0, counters retained.
- Force capability_issued_count_o near saturation (CNT_W=4) with repeated cap pushes → holds at 15; assert rst_i mid-burst → async clear of all outputs.
